loop_index_counter: RTL and testbench

//   Nested-loop index datapath driven by the loop-control FSM. It consumes the FSM's

---
 rtl/loop_index_counter.sv | 148 ++++++++++++++
 tb/tb_loop_index_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_index_counter.sv
// Nested-loop index datapath: inner index j, outer index i, flat address addr = i*(J_MAX+1)+j.
// Latency: i/j/addr/done update one clk_in edge after the strobe; j_last/i_last are combinational.
// Backpressure: none; strobes are accepted every cycle, indices saturate at their terminal values.
// Optional feature: define LOOP_ERR_EN to build the sticky protocol-error flag (err tied to 0 otherwise).
module loop_index_counter #(
  parameter int IW    = 4,
  parameter int JW    = 3,
  parameter int I_MAX = 8,
  parameter int J_MAX = 6,
  parameter int AW    = 7
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic          reset_j,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [AW-1:0] addr,
  output logic          j_last,
  output logic          i_last,
  output logic          done,
  output logic          err
);

  // Terminal values and the row stride, sized to the registers they are compared with.
  localparam logic [IW-1:0] I_TERM = IW'(I_MAX);
  localparam logic [JW-1:0] J_TERM = JW'(J_MAX);
  localparam logic [AW-1:0] STRIDE = AW'(J_MAX + 1);

  // Registered state. base tracks i*(J_MAX+1) so the address never needs a multiplier.
  logic [IW-1:0] i_q,    i_d;
  logic [JW-1:0] j_q,    j_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          done_q, done_d;

  // Decoded strobes, already masked by load so each is mutually exclusive.
  logic inner_clr;
  logic outer_adv;
  logic inner_inc;
  logic at_i_term;
  logic at_j_term;

  // Decode the FSM strobes in priority order: load, inner clear, outer advance, inner increment.
  always_comb begin
    inner_clr = 1'b0;
    outer_adv = 1'b0;
    inner_inc = 1'b0;
    if (!load) begin
      inner_clr = reset_j & en;
      outer_adv = reset_j & ~en;
      inner_inc = ~reset_j & en;
    end
    at_i_term = (i_q >= I_TERM);
    at_j_term = (j_q >= J_TERM);
  end

  // Next-state for indices, base and address; terminal values saturate instead of wrapping.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    base_d = base_q;
    addr_d = addr_q;
    if (load) begin
      i_d    = '0;
      j_d    = '0;
      base_d = '0;
      addr_d = '0;
    end else if (inner_clr) begin
      j_d    = '0;
      addr_d = base_q;
    end else if (outer_adv) begin
      j_d = '0;
      if (!at_i_term) begin
        i_d    = i_q + IW'(1);
        base_d = base_q + STRIDE;
        addr_d = base_q + STRIDE;
      end else begin
        addr_d = base_q;
      end
    end else if (inner_inc && !at_j_term) begin
      j_d    = j_q + JW'(1);
      addr_d = addr_q + AW'(1);
    end
  end

  // done is set when i lands on its terminal value and stays set until load or reset.
  always_comb begin
    done_d = done_q;
    if (load) begin
      done_d = 1'b0;
    end else if (i_d == I_TERM) begin
      done_d = 1'b1;
    end
  end

  // State registers; reset clears immediately, independent of the clock.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      i_q    <= '0;
      j_q    <= '0;
      base_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      base_q <= base_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

`ifdef LOOP_ERR_EN
  logic err_q;
  logic err_d;

  // A request that would push an index past its terminal value is a protocol error.
  always_comb begin
    err_d = err_q;
    if ((inner_inc && at_j_term) || (outer_adv && at_i_term)) begin
      err_d = 1'b1;
    end
  end

  // Sticky error flag; only reset clears it, load deliberately leaves it alone.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign i      = i_q;
  assign j      = j_q;
  assign addr   = addr_q;
  assign done   = done_q;
  assign j_last = (j_q == J_TERM);
  assign i_last = (i_q == I_TERM);

endmodule

// File: tb/tb_loop_index_counter.sv
// Bench for loop_index_counter: directed loop scenarios plus randomized strobes,
// checked every cycle against an arithmetic model of the nested loop and a few literal values.
module tb_loop_index_counter;

  localparam int IW    = 4;
  localparam int JW    = 3;
  localparam int I_MAX = 8;
  localparam int J_MAX = 6;
  localparam int AW    = 7;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b0;
  logic          load   = 1'b0;
  logic          en     = 1'b0;
  logic          reset_j = 1'b0;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [AW-1:0] addr;
  logic          j_last;
  logic          i_last;
  logic          done;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model: plain integer loop counters.
  int m_i = 0;
  int m_j = 0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;

`ifdef LOOP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  loop_index_counter #(
    .IW(IW), .JW(JW), .I_MAX(I_MAX), .J_MAX(J_MAX), .AW(AW)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (load),
    .en     (en),
    .reset_j(reset_j),
    .i      (i),
    .j      (j),
    .addr   (addr),
    .j_last (j_last),
    .i_last (i_last),
    .done   (done),
    .err    (err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update, written from the loop rules rather than from any register structure.
  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      m_i = 0; m_j = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      if (load) begin
        m_i = 0; m_j = 0; m_done = 1'b0;
      end else if (reset_j && en) begin
        m_j = 0;
      end else if (reset_j) begin
        if (m_i < I_MAX) m_i = m_i + 1;
        else if (ERR_ON) m_err = 1'b1;
        m_j = 0;
      end else if (en) begin
        if (m_j < J_MAX) m_j = m_j + 1;
        else if (ERR_ON) m_err = 1'b1;
      end
      if (m_i == I_MAX) m_done = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_on) begin
      chk("i",      int'(i),      m_i);
      chk("j",      int'(j),      m_j);
      chk("addr",   int'(addr),   m_i * (J_MAX + 1) + m_j);
      chk("j_last", int'(j_last), int'(m_j == J_MAX));
      chk("i_last", int'(i_last), int'(m_i == I_MAX));
      chk("done",   int'(done),   int'(m_done));
      chk("err",    int'(err),    int'(m_err));
    end
  end

  // Drive one set of strobes for exactly one edge; returns just after that edge.
  task automatic step(input bit ld, input bit e, input bit rj);
    @(negedge clk_in);
    load = ld; en = e; reset_j = rj;
    @(posedge clk_in);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_i"},      int'(i),      0);
    chk({tag, "_j"},      int'(j),      0);
    chk({tag, "_addr"},   int'(addr),   0);
    chk({tag, "_done"},   int'(done),   0);
    chk({tag, "_err"},    int'(err),    0);
    chk({tag, "_j_last"}, int'(j_last), 0);
    chk({tag, "_i_last"}, int'(i_last), 0);
  endtask

  initial begin
    // Power-on reset state.
    #3;
    all_zero("por");
    reset = 1'b1;
    chk_on = 1'b1;

    // Async reset mid-count at i=3, j=4.
    step(1, 0, 0);
    repeat (3) step(0, 0, 1);
    repeat (4) step(0, 1, 0);
    chk("t1_pre_i", int'(i), 3);
    chk("t1_pre_addr", int'(addr), 25);
    #1 reset = 1'b0;
    #1 all_zero("t1_async");
    #1 reset = 1'b1;

    // Inner count to saturation.
    step(1, 0, 0);
    repeat (6) step(0, 1, 0);
    chk("t2_j", int'(j), 6);
    chk("t2_addr", int'(addr), 6);
    chk("t2_j_last", int'(j_last), 1);
    step(0, 1, 0);
    chk("t2_sat_j", int'(j), 6);
    chk("t2_sat_addr", int'(addr), 6);
    chk("t2_sat_err", int'(err), int'(ERR_ON));

    // Outer advance, then inner clear.
    step(0, 0, 1);
    chk("t3_i", int'(i), 1);
    chk("t3_j", int'(j), 0);
    chk("t3_addr", int'(addr), 7);
    step(0, 1, 1);
    chk("t3_clr_j", int'(j), 0);
    chk("t3_clr_addr", int'(addr), 7);

    // Full sweep; a fresh reset clears the sticky error first.
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    step(1, 0, 0);
    for (int k = 0; k < I_MAX; k++) begin
      step(0, 1, 1);
      repeat (J_MAX) step(0, 1, 0);
      step(0, 0, 1);
    end
    chk("t4_i", int'(i), 8);
    chk("t4_done", int'(done), 1);
    chk("t4_i_last", int'(i_last), 1);
    chk("t4_addr", int'(addr), 56);
    chk("t4_err", int'(err), 0);

    // Outer advance requested at the terminal row.
    step(0, 0, 1);
    chk("t5_i", int'(i), 8);
    chk("t5_j", int'(j), 0);
    chk("t5_addr", int'(addr), 56);
    chk("t5_err", int'(err), int'(ERR_ON));

    // load beats a simultaneous inner clear at i=5, j=3.
    step(1, 0, 0);
    repeat (5) step(0, 0, 1);
    repeat (3) step(0, 1, 0);
    chk("t6_pre_addr", int'(addr), 38);
    step(1, 1, 1);
    chk("t6_i", int'(i), 0);
    chk("t6_j", int'(j), 0);
    chk("t6_addr", int'(addr), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_err_kept", int'(err), int'(ERR_ON));

    // Randomized strobes with occasional load and async reset pulses.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 3), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 99) < 25));
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end

    step(0, 0, 0);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
